// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DISCARD = 2'd1,
        HALT    = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam int          EXP_ADEL_BIT     = 0;
    localparam int          INST_EXP_W       = 12;

    // PC following a returned pair: one or two words consumed, 32-bit wrap.
    function automatic logic [31:0] pair_next_pc(input logic [31:0] addr,
                                                 input logic        two_words);
        return addr + (two_words ? 32'd8 : 32'd4);
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, keeps one dual-word I-cache request
// in flight, writes returned pairs into the instruction FIFO and drops a
// response whose request was overtaken by a redirect.
module inst_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    input  logic                  fifo_full,
    output logic                  inst_req,
    output logic [31:0]           inst_addr,
    input  logic                  inst_ok,
    input  logic                  inst_ok_2,
    input  logic [31:0]           inst_rdata_1,
    input  logic [31:0]           inst_rdata_2,
    output logic                  fifo_write_en1,
    output logic                  fifo_write_en2,
    output logic [31:0]           fifo_write_data1,
    output logic [31:0]           fifo_write_data2,
    output logic [31:0]           fifo_write_address1,
    output logic [31:0]           fifo_write_address2,
    output logic [INST_EXP_W-1:0] fifo_write_inst_exp1,
    output logic [31:0]           fetch_pc,
    output logic [31:0]           fetch_count,
    output logic [31:0]           discard_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_addr_q;
    logic         outstanding_q;
    logic [31:0]  fetch_count_q, discard_count_q;
    logic [31:0]  req_base;
    logic         issue, accept, drop, adel;

    assign fetch_pc      = fetch_pc_q;
    assign fetch_count   = fetch_count_q;
    assign discard_count = discard_count_q;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // Next-state: a redirect over a pending request waits out its response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH: begin
                if (redirect_valid && outstanding_q && !inst_ok) state_d = DISCARD;
                else if (adel)                                   state_d = HALT;
            end
            DISCARD: if (inst_ok)        state_d = FETCH;
            HALT:    if (redirect_valid) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // Output decode: request, FIFO write side and next fetch PC.
    always_comb begin
        req_base             = outstanding_q ? req_addr_q : fetch_pc_q;
        inst_req             = 1'b0;
        inst_addr            = req_base;
        fifo_write_en1       = 1'b0;
        fifo_write_en2       = 1'b0;
        fifo_write_data1     = inst_rdata_1;
        fifo_write_data2     = inst_rdata_2;
        fifo_write_address1  = req_base;
        fifo_write_address2  = req_base + 32'd4;
        fifo_write_inst_exp1 = '0;
        fetch_pc_d           = fetch_pc_q;
        issue                = 1'b0;
        accept               = 1'b0;
        drop                 = 1'b0;
        adel                 = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    if (redirect_valid) begin
                        // A fresh request is suppressed; a pending one stays up.
                        fetch_pc_d = redirect_pc;
                        if (outstanding_q) begin
                            inst_req = 1'b1;
                            drop     = inst_ok;
                        end
                    end else if (outstanding_q) begin
                        inst_req = 1'b1;
                        accept   = inst_ok;
                    end else if (fetch_pc_q[1:0] != 2'b00) begin
                        adel = !fifo_full;
                    end else if (!fifo_full) begin
                        inst_req = 1'b1;
                        accept   = inst_ok;
                        issue    = !inst_ok;
                    end
                    if (accept) begin
                        fifo_write_en1 = 1'b1;
                        fifo_write_en2 = inst_ok_2;
                        fetch_pc_d     = pair_next_pc(req_base, inst_ok_2);
                    end
                    if (adel) begin
                        fifo_write_en1                     = 1'b1;
                        fifo_write_data1                   = '0;
                        fifo_write_inst_exp1[EXP_ADEL_BIT] = 1'b1;
                    end
                end
                DISCARD: begin
                    inst_req = 1'b1;
                    drop     = inst_ok;
                    if (redirect_valid) fetch_pc_d = redirect_pc;
                end
                HALT: begin
                    if (redirect_valid) fetch_pc_d = redirect_pc;
                end
                default: ;
            endcase
        end
    end

    // Architectural fetch PC.
    always_ff @(posedge clk) begin
        if (rst) fetch_pc_q <= RESET_PC;
        else     fetch_pc_q <= fetch_pc_d;
    end

    // Latched request address and the single-outstanding flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr_q    <= RESET_PC;
            outstanding_q <= 1'b0;
        end else if (issue) begin
            req_addr_q    <= fetch_pc_q;
            outstanding_q <= 1'b1;
        end else if (accept || drop) begin
            outstanding_q <= 1'b0;
        end
    end

    // Wrapping response counters: written vs dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q   <= '0;
            discard_count_q <= '0;
        end else begin
            if (accept) fetch_count_q   <= fetch_count_q + 32'd1;
            if (drop)   discard_count_q <= discard_count_q + 32'd1;
        end
    end

endmodule
